// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared address map, read-select type and decode helper for mem_bus
package mem_bus_pkg;

    // System address map. Software and assembler tables are generated from these values.
    localparam logic [15:0] RAM_BASE_ADDR  = 16'h0000;
    localparam logic [15:0] UART_DATA_ADDR = 16'h8000;
    localparam logic [15:0] UART_STAT_ADDR = 16'h8001;
    localparam logic [15:0] LED_ADDR       = 16'h8002;
    localparam logic [15:0] TIMER_ADDR     = 16'h8003;

    // Source of o_read_data for the cycle after an address is captured.
    typedef enum logic {
        RD_SEL_REG = 1'b0,
        RD_SEL_RAM = 1'b1
    } rd_sel_e;

    // True when addr lands inside the RAM window of 2**aw words starting at RAM_BASE_ADDR.
    function automatic logic addr_in_ram(input logic [15:0] addr, input int aw);
        logic [15:0] offset;
        offset = addr - RAM_BASE_ADDR;
        return (aw >= 16) || ((offset >> aw) == 16'd0);
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - core read/write port, UART TX stream and LED bundle for mem_bus
// master: core side (drives addresses, write data/strobe, tx_ready)
// slave : mem_bus side (drives read_data, tx_data/tx_valid, led)
interface mem_bus_if;
    logic [15:0] read_addr;
    logic [15:0] read_data;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_strobe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  led;

    modport master (
        output read_addr, write_addr, write_data, write_strobe, tx_ready,
        input  read_data, tx_data, tx_valid, led
    );

    modport slave (
        input  read_addr, write_addr, write_data, write_strobe, tx_ready,
        output read_data, tx_data, tx_valid, led
    );
endinterface

// File: rtl/mem_bus_sync_fifo.sv
// rtl/mem_bus_sync_fifo.sv - synchronous FIFO with same-edge push-into-full-on-pop support
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_data, i_pop,
//        o_head (head entry, 0 when empty), o_full, o_empty
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_ok;
    logic             push_ok;

    assign o_empty = (count == '0);
    assign o_full  = (count == FULL_CNT);

    // A pop on an empty FIFO is ignored; a push into a full FIFO is taken only
    // when a pop frees the head slot at the same edge.
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    // Empty shows zero so the head output has a defined reset value without resetting storage.
    assign o_head = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus.sv
// rtl/mem_bus.sv - core-facing fabric: RAM, UART TX FIFO, LED register and timer behind a flat 16-bit map
// Ports: i_clk, i_rst_n (async active-low), bus (mem_bus_if.slave: read port with 1-cycle
//        registered data, single-cycle write strobe, UART TX stream, LED register)
module mem_bus
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_W = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMER_DIV  = 1
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    mem_bus_if.slave  bus
);

    localparam int               RAM_WORDS = 2 ** RAM_ADDR_W;
    localparam int               PRE_W     = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TC    = PRE_W'(TIMER_DIV - 1);

    // RAM: registered read, no reset, old data returned on a same-address write.
    logic [15:0] ram [RAM_WORDS];
    logic [15:0] ram_q;
    logic        ram_we;

    assign ram_we = bus.write_strobe && addr_in_ram(bus.write_addr, RAM_ADDR_W);

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram[bus.write_addr[RAM_ADDR_W-1:0]] <= bus.write_data;
        end
        ram_q <= ram[bus.read_addr[RAM_ADDR_W-1:0]];
    end

    // Write decode
    logic push;
    logic stat_we;
    logic led_we;
    logic timer_we;

    assign push     = bus.write_strobe && (bus.write_addr == UART_DATA_ADDR);
    assign stat_we  = bus.write_strobe && (bus.write_addr == UART_STAT_ADDR);
    assign led_we   = bus.write_strobe && (bus.write_addr == LED_ADDR);
    assign timer_we = bus.write_strobe && (bus.write_addr == TIMER_ADDR);

    // UART TX FIFO
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       tx_pop;
    logic       drop;

    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_head;
    assign tx_pop       = bus.tx_valid && bus.tx_ready;
    assign drop         = push && fifo_full && !tx_pop;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (bus.write_data[7:0]),
        .i_pop       (tx_pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // Peripheral registers
    logic             ovf_q;
    logic [7:0]       led_q;
    logic [15:0]      timer_q;
    logic [PRE_W-1:0] presc_q;

    assign bus.led = led_q;

    // Peripheral read value from pre-update state, registered alongside the RAM read.
    logic [15:0] periph_rd;
    rd_sel_e     rd_sel_q;
    logic [15:0] periph_q;

    always_comb begin
        periph_rd = 16'h0000;
        case (bus.read_addr)
            UART_STAT_ADDR: periph_rd = {13'b0, ovf_q, fifo_full, fifo_empty};
            LED_ADDR:       periph_rd = {8'h00, led_q};
            TIMER_ADDR:     periph_rd = timer_q;
            default:        periph_rd = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_sel_q <= RD_SEL_REG;
            periph_q <= 16'h0000;
            ovf_q    <= 1'b0;
            led_q    <= 8'h00;
            timer_q  <= 16'h0000;
            presc_q  <= '0;
        end else begin
            rd_sel_q <= addr_in_ram(bus.read_addr, RAM_ADDR_W) ? RD_SEL_RAM : RD_SEL_REG;
            periph_q <= periph_rd;

            // A dropped byte wins over a same-edge clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (stat_we) begin
                ovf_q <= 1'b0;
            end

            if (led_we) begin
                led_q <= bus.write_data[7:0];
            end

            if (timer_we) begin
                timer_q <= bus.write_data;
                presc_q <= '0;
            end else if (presc_q == PRE_TC) begin
                timer_q <= timer_q + 16'd1;
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end
        end
    end

    // Final mux sits after the RAM output register.
    assign bus.read_data = (rd_sel_q == RD_SEL_RAM) ? ram_q : periph_q;

endmodule

// File: tb/tb_mem_bus.sv
// tb/tb_mem_bus.sv - self-checking bench for mem_bus
module tb_mem_bus;

    localparam int TDIV  = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_bus_if bus ();

    mem_bus #(
        .RAM_ADDR_W (12),
        .FIFO_DEPTH (DEPTH),
        .TIMER_DIV  (TDIV)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] ram_m [int];
    logic [7:0]  q_m [$];
    logic        ovf_m;
    logic [7:0]  led_m;
    logic [15:0] t_base;
    int          t_cnt;

    typedef struct {
        logic [15:0] ra;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        ws;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q_m.delete();
        ovf_m  = 1'b0;
        led_m  = 8'h00;
        t_base = 16'h0000;
        t_cnt  = 0;
    endfunction

    function automatic void model_read(input logic [15:0] ra, output logic [15:0] v, output bit known);
        known = 1'b1;
        v     = 16'h0000;
        if (ra < 16'h1000) begin
            if (ram_m.exists(int'(ra))) v = ram_m[int'(ra)];
            else known = 1'b0;
        end else if (ra == 16'h8001) begin
            v = {13'b0, ovf_m, (q_m.size() == DEPTH), (q_m.size() == 0)};
        end else if (ra == 16'h8002) begin
            v = {8'h00, led_m};
        end else if (ra == 16'h8003) begin
            v = 16'(int'(t_base) + t_cnt / TDIV);
        end
    endfunction

    task automatic check_outputs();
        logic [7:0] head;
        head = (q_m.size() != 0) ? q_m[0] : 8'h00;
        check16("tx_valid", {15'd0, bus.tx_valid}, {15'd0, (q_m.size() != 0)});
        check16("tx_data", {8'd0, bus.tx_data}, {8'd0, head});
        check16("led", {8'd0, bus.led}, {8'd0, led_m});
    endtask

    // One clock: drive inputs, advance the model across the edge, check #1 after it.
    task automatic step(input logic [15:0] ra, input logic [15:0] wa, input logic [15:0] wd,
                        input logic ws, input logic rdy);
        logic [15:0] exp_rd;
        bit          known;
        bit          pop;
        bit          push;
        bit          drop;
        bus.read_addr    = ra;
        bus.write_addr   = wa;
        bus.write_data   = wd;
        bus.write_strobe = ws;
        bus.tx_ready     = rdy;
        model_read(ra, exp_rd, known);
        pop  = (q_m.size() > 0) && rdy;
        push = ws && (wa == 16'h8000);
        drop = push && (q_m.size() == DEPTH) && !pop;
        @(posedge clk);
        if (pop) void'(q_m.pop_front());
        if (push && !drop) q_m.push_back(wd[7:0]);
        if (drop) ovf_m = 1'b1;
        else if (ws && wa == 16'h8001) ovf_m = 1'b0;
        if (ws && wa == 16'h8002) led_m = wd[7:0];
        if (ws && wa == 16'h8003) begin
            t_base = wd;
            t_cnt  = 0;
        end else begin
            t_cnt++;
        end
        if (ws && wa < 16'h1000) ram_m[int'(wa)] = wd;
        #1;
        if (known) check16("read_data", bus.read_data, exp_rd);
        check_outputs();
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 16'($urandom_range(0, 15));
            4:          a = 16'h8000;
            5:          a = 16'h8001;
            6:          a = 16'h8002;
            7:          a = 16'h8003;
            8:          a = 16'h8004 + 16'($urandom_range(0, 3));
            default:    a = 16'h1000 | 16'($urandom_range(0, 15));
        endcase
        return a;
    endfunction

    initial begin
        vecs[0]  = '{16'h8002, 16'h0010, 16'h1234, 1'b1, 16'h0000};
        vecs[1]  = '{16'h0010, 16'h0000, 16'h0000, 1'b0, 16'h1234};
        vecs[2]  = '{16'h8001, 16'h0020, 16'h0001, 1'b1, 16'h0001};
        vecs[3]  = '{16'h0020, 16'h0020, 16'hBEEF, 1'b1, 16'h0001};
        vecs[4]  = '{16'h0020, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};
        vecs[5]  = '{16'h8002, 16'h8002, 16'h12A5, 1'b1, 16'h0000};
        vecs[6]  = '{16'h8002, 16'h0000, 16'h0000, 1'b0, 16'h00A5};
        vecs[7]  = '{16'h8000, 16'h0000, 16'h0F0F, 1'b1, 16'h0000};
        vecs[8]  = '{16'h8004, 16'h1000, 16'h7777, 1'b1, 16'h0000};
        vecs[9]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0F0F};
        vecs[10] = '{16'h1000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{16'h8001, 16'h8001, 16'hFFFF, 1'b1, 16'h0001};
        vecs[12] = '{16'h0010, 16'h0000, 16'h0000, 1'b0, 16'h1234};

        rst_n            = 1'b0;
        bus.read_addr    = 16'h0000;
        bus.write_addr   = 16'h0000;
        bus.write_data   = 16'h0000;
        bus.write_strobe = 1'b0;
        bus.tx_ready     = 1'b0;
        model_reset();
        #1;
        check16("rst_read_data", bus.read_data, 16'h0000);
        check16("rst_tx_valid", {15'd0, bus.tx_valid}, 16'h0000);
        check16("rst_tx_data", {8'd0, bus.tx_data}, 16'h0000);
        check16("rst_led", {8'd0, bus.led}, 16'h0000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed vectors: RAM latency, read-before-write, LED, unmapped and aliasing
        for (int i = 0; i < $size(vecs); i++) begin
            step(vecs[i].ra, vecs[i].wa, vecs[i].wd, vecs[i].ws, 1'b0);
            check16($sformatf("vec%0d", i), bus.read_data, vecs[i].exp_rd);
        end

        // Overflow: nine pushes with the UART stalled, ninth byte lost
        for (int i = 0; i < 9; i++) step(16'h8000, 16'h8000, 16'(16'h41 + i), 1'b1, 1'b0);
        step(16'h8001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check16("ovf_status", bus.read_data, 16'h0006);
        for (int i = 0; i < 8; i++) begin
            check16("drain_valid", {15'd0, bus.tx_valid}, 16'h0001);
            check16("drain_head", {8'd0, bus.tx_data}, 16'(16'h41 + i));
            step(16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        end
        check16("drained_valid", {15'd0, bus.tx_valid}, 16'h0000);
        step(16'h8001, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check16("drained_status", bus.read_data, 16'h0005);

        // Push into a full FIFO on the same edge as a pop
        step(16'h8002, 16'h8001, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(16'h8000, 16'h8000, 16'(16'h60 + i), 1'b1, 1'b0);
        step(16'h8001, 16'h8000, 16'h0055, 1'b1, 1'b1);
        check16("full_pushpop_pre", bus.read_data, 16'h0002);
        step(16'h8001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check16("full_pushpop_post", bus.read_data, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            check16("pp_head", {8'd0, bus.tx_data}, (i < 7) ? 16'(16'h61 + i) : 16'h0055);
            step(16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        end
        step(16'h8001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check16("pp_status", bus.read_data, 16'h0001);

        // Timer with divide-by-4, wrapping through 0xFFFF
        step(16'h8000, 16'h8003, 16'hFFFE, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(16'h8003, 16'h0000, 16'h0000, 1'b0, 1'b0);
            check16($sformatf("timer_k%0d", k), bus.read_data, 16'(32'hFFFE + (k - 1) / 4));
        end

        // Asynchronous reset mid-drain
        step(16'h8000, 16'h8002, 16'h003C, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(16'h8000, 16'h8000, 16'(16'h71 + i), 1'b1, 1'b0);
        step(16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check16("pre_rst_valid", {15'd0, bus.tx_valid}, 16'h0001);
        check16("pre_rst_led", {8'd0, bus.led}, 16'h003C);
        #2 rst_n = 1'b0;
        #1;
        check16("async_tx_valid", {15'd0, bus.tx_valid}, 16'h0000);
        check16("async_led", {8'd0, bus.led}, 16'h0000);
        check16("async_read_data", bus.read_data, 16'h0000);
        check16("async_tx_data", {8'd0, bus.tx_data}, 16'h0000);
        model_reset();
        bus.write_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step(16'h8001, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check16("post_rst_status", bus.read_data, 16'h0001);

        // Random traffic against the reference model; seed the RAM window first
        for (int i = 0; i < 16; i++) step(16'h8001, 16'(i), 16'($urandom), 1'b1, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            step(pick_addr(), pick_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
